// File: rtl/abff_pkg.sv
// abff_pkg
// Shared definitions for the AB flip-flop excitation driver.
//   AB_HOLD / AB_RESET / AB_TOGGLE / AB_SET : 2-bit {a,b} command encodings
//   drv_state_t                             : driver FSM states
package abff_pkg;

   localparam logic [1:0] AB_HOLD   = 2'b00;
   localparam logic [1:0] AB_RESET  = 2'b01;
   localparam logic [1:0] AB_TOGGLE = 2'b10;
   localparam logic [1:0] AB_SET    = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } drv_state_t;

endpackage

// File: rtl/abff_excite.sv
// abff_excite
// Combinational excitation table for the AB flip-flop: picks the {a,b}
// command that moves the current state q to the target d on the next edge.
// Parameters:
//   TOGGLE_PREF : 0 -> state changes use set/reset, 1 -> state changes use toggle
// Ports:
//   d  : target flip-flop value
//   q  : current flip-flop value
//   ab : {a,b} command to apply
module abff_excite
   import abff_pkg::*;
#(
   parameter int TOGGLE_PREF = 0
) (
   input  logic       d,
   input  logic       q,
   output logic [1:0] ab
);

   // No change needed means hold; otherwise pick the preferred way of
   // flipping the stored value.
   always_comb begin
      ab = AB_HOLD;
      if (d != q) begin
         if (TOGGLE_PREF != 0) begin
            ab = AB_TOGGLE;
         end else begin
            ab = d ? AB_SET : AB_RESET;
         end
      end
   end

endmodule

// File: rtl/abff_drive.sv
// abff_drive
// Serialises WIDTH-bit words (LSB first) into registered {a,b} excitation
// commands for an AB flip-flop, tracking the flip-flop state internally.
// Optional feedback checking is enabled with the macro ABFF_DRV_CHECK_EN.
// Parameters:
//   WIDTH       : bits per input word (>= 2)
//   TOGGLE_PREF : 0 -> set/reset for state changes, 1 -> toggle
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : word offered
//   in_ready   : driver can accept a word this cycle
//   in_data    : word to serialise, bit 0 first
//   a, b       : registered flip-flop excitation
//   busy       : a word is being driven
//   q_pred     : flip-flop value after the next edge
//   q_fb       : flip-flop q feedback (ABFF_DRV_CHECK_EN only)
//   mismatch   : sticky feedback error (ABFF_DRV_CHECK_EN only)
module abff_drive
   import abff_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int TOGGLE_PREF = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             q_pred
`ifdef ABFF_DRV_CHECK_EN
   ,
   input  logic             q_fb,
   output logic             mismatch
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   drv_state_t       state;
   drv_state_t       state_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [WIDTH-2:0] shifter;
   logic [WIDTH-2:0] shifter_nxt;
   logic [1:0]       ab_nxt;
   logic [1:0]       ex_ab;
   logic             q_pred_nxt;
   logic             accept;
   logic             d_sel;

   assign in_ready = (cnt == '0) && !rst;
   assign accept   = in_valid && in_ready;
   assign busy     = (state == SHIFT);

   // The bit to drive next is bit 0 of a freshly accepted word, otherwise
   // the head of the shifter.
   assign d_sel = accept ? in_data[0] : shifter[0];

   abff_excite #(
      .TOGGLE_PREF (TOGGLE_PREF)
   ) u_excite (
      .d  (d_sel),
      .q  (q_pred),
      .ab (ex_ab)
   );

   // Next-state logic. An accept in the last bit cycle starts the next word
   // immediately, so back-to-back words have no idle gap.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      shifter_nxt = shifter;
      ab_nxt      = AB_HOLD;
      q_pred_nxt  = q_pred;
      if (accept) begin
         ab_nxt      = ex_ab;
         q_pred_nxt  = d_sel;
         shifter_nxt = in_data[WIDTH-1:1];
         cnt_nxt     = CW'(WIDTH - 1);
         state_nxt   = SHIFT;
      end else if (cnt != '0) begin
         ab_nxt      = ex_ab;
         q_pred_nxt  = d_sel;
         shifter_nxt = shifter >> 1;
         cnt_nxt     = cnt - CW'(1);
      end else begin
         state_nxt   = IDLE;
      end
   end

   // State register. During reset the flip-flop is commanded to clear, and
   // any partially driven word is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         shifter <= '0;
         a       <= AB_RESET[1];
         b       <= AB_RESET[0];
         q_pred  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         shifter <= shifter_nxt;
         a       <= ab_nxt[1];
         b       <= ab_nxt[0];
         q_pred  <= q_pred_nxt;
      end
   end

`ifdef ABFF_DRV_CHECK_EN
   logic q_exp;
   logic chk_arm;

   // q_pred leads the flip-flop by one edge, so a one-edge delayed copy is
   // what q_fb should equal now. The first edge after reset is skipped
   // because q_exp still holds a value captured during reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_exp    <= 1'b0;
         chk_arm  <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         q_exp   <= q_pred;
         chk_arm <= 1'b1;
         if (chk_arm && (q_fb != q_exp)) begin
            mismatch <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_abff_drive.sv
// tb_abff_drive
// Directed bench for abff_drive: two instances (set/reset and toggle
// preference) share one stimulus stream, each feeding a behavioural AB
// flip-flop. Build with ABFF_DRV_CHECK_EN to also exercise the feedback check.
module tb_abff_drive;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready0, a0, b0, busy0, qp0;
   logic       in_ready1, a1, b1, busy1, qp1;
   logic       ffq0 = 1'b0;
   logic       ffq1 = 1'b0;
   int         vectors = 0;
   int         miscompares = 0;

`ifdef ABFF_DRV_CHECK_EN
   logic inv = 1'b0;
   logic q_fb0;
   logic mismatch0, mismatch1;
   assign q_fb0 = ffq0 ^ inv;
`endif

   always #5 clk = ~clk;

   abff_drive #(.WIDTH(8), .TOGGLE_PREF(0)) dut0 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready0),
      .in_data  (in_data),
      .a        (a0),
      .b        (b0),
      .busy     (busy0),
      .q_pred   (qp0)
`ifdef ABFF_DRV_CHECK_EN
      ,
      .q_fb     (q_fb0),
      .mismatch (mismatch0)
`endif
   );

   abff_drive #(.WIDTH(8), .TOGGLE_PREF(1)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready1),
      .in_data  (in_data),
      .a        (a1),
      .b        (b1),
      .busy     (busy1),
      .q_pred   (qp1)
`ifdef ABFF_DRV_CHECK_EN
      ,
      .q_fb     (ffq1),
      .mismatch (mismatch1)
`endif
   );

   // Behavioural AB flip-flops: 00 hold, 01 reset, 10 toggle, 11 set.
   always @(posedge clk) begin
      case ({a0, b0})
         2'b01:   ffq0 <= 1'b0;
         2'b10:   ffq0 <= ~ffq0;
         2'b11:   ffq0 <= 1'b1;
         default: ffq0 <= ffq0;
      endcase
      case ({a1, b1})
         2'b01:   ffq1 <= 1'b0;
         2'b10:   ffq1 <= ~ffq1;
         2'b11:   ffq1 <= 1'b1;
         default: ffq1 <= ffq1;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] d);
      in_valid = v;
      in_data  = d;
   endtask

   task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic checkAb(input string tag, input logic [1:0] e0, input logic [1:0] e1);
      checkOutput({tag, " ab sr"}, {a0, b0}, e0);
      checkOutput({tag, " ab tg"}, {a1, b1}, e1);
   endtask

   task automatic checkFf(input string tag, input logic e);
      checkOutput({tag, " q sr"}, {1'b0, ffq0}, {1'b0, e});
      checkOutput({tag, " q tg"}, {1'b0, ffq1}, {1'b0, e});
   endtask

   initial begin
      logic [1:0] a5_sr [8];
      logic [1:0] a5_tg [8];
      logic       a5_bit [8];
      logic [1:0] b2b_sr [16];
      logic [1:0] b2b_tg [16];
      logic [1:0] w01_sr [8];
      logic [1:0] w01_tg [8];

      a5_sr  = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01, 2'b11};
      a5_tg  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10};
      a5_bit = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      b2b_sr = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      b2b_tg = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      // 8'h01 LSB first is 1,0,0,...: the second bit must clear the 1.
      w01_sr = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      w01_tg = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

      // Reset for two edges
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00);
      tick();
      tick();
      checkAb("reset", 2'b01, 2'b01);
      checkOutput("reset q_pred", {1'b0, qp0}, 2'b00);
      checkOutput("reset in_ready", {1'b0, in_ready0}, 2'b00);
      checkOutput("reset busy", {1'b0, busy0}, 2'b00);
      rst = 1'b0;
      #1;
      checkOutput("release in_ready", {1'b0, in_ready0}, 2'b01);
      tick();
      checkAb("after release", 2'b00, 2'b00);
      checkFf("after release", 1'b0);

      // Word 8'hA5
      applyStimulus(1'b1, 8'hA5);
      tick();
      applyStimulus(1'b0, 8'h00);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         checkAb($sformatf("a5 bit%0d", k), a5_sr[k], a5_tg[k]);
         checkOutput($sformatf("a5 q_pred%0d", k), {1'b0, qp0}, {1'b0, a5_bit[k]});
         checkOutput($sformatf("a5 in_ready%0d", k), {1'b0, in_ready0}, {1'b0, (k == 7)});
         checkOutput($sformatf("a5 busy%0d", k), {1'b0, busy1}, 2'b01);
         if (k > 0) checkFf($sformatf("a5 bit%0d", k - 1), a5_bit[k - 1]);
      end
      tick();
      checkAb("a5 done", 2'b00, 2'b00);
      checkOutput("a5 done busy", {busy0, busy1}, 2'b00);
      checkFf("a5 bit7", 1'b1);

      // Idle for five cycles
      for (int k = 0; k < 5; k++) begin
         tick();
         checkAb($sformatf("idle%0d", k), 2'b00, 2'b00);
         checkOutput($sformatf("idle q_pred%0d", k), {qp0, qp1}, 2'b11);
         checkOutput($sformatf("idle in_ready%0d", k), {in_ready0, in_ready1}, 2'b11);
         checkFf($sformatf("idle%0d", k), 1'b1);
      end

      // Back-to-back 8'hFF then 8'h00 from a fresh reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      applyStimulus(1'b1, 8'hFF);
      tick();
      in_data = 8'h00;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) tick();
         if (k == 8) applyStimulus(1'b0, 8'h00);
         checkAb($sformatf("b2b cyc%0d", k), b2b_sr[k], b2b_tg[k]);
         checkOutput($sformatf("b2b busy%0d", k), {busy0, busy1}, 2'b11);
         checkOutput($sformatf("b2b in_ready%0d", k), {1'b0, in_ready0},
                     {1'b0, (k == 7) || (k == 15)});
      end
      tick();
      checkAb("b2b done", 2'b00, 2'b00);
      checkOutput("b2b done busy", {busy0, busy1}, 2'b00);
      checkFf("b2b done", 1'b0);

      // Reset during bit 3 of 8'hF0
      applyStimulus(1'b1, 8'hF0);
      tick();
      applyStimulus(1'b0, 8'h00);
      tick();
      tick();
      tick();
      checkAb("f0 bit3", 2'b00, 2'b00);
      rst = 1'b1;
      tick();
      checkAb("midword reset", 2'b01, 2'b01);
      checkOutput("midword q_pred", {qp0, qp1}, 2'b00);
      checkOutput("midword busy", {busy0, busy1}, 2'b00);
      tick();
      rst = 1'b0;
      applyStimulus(1'b1, 8'h01);
      #1;
      checkOutput("midword in_ready", {in_ready0, in_ready1}, 2'b11);
      tick();
      applyStimulus(1'b0, 8'h00);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         checkAb($sformatf("w01 bit%0d", k), w01_sr[k], w01_tg[k]);
      end
      tick();
      checkAb("w01 done", 2'b00, 2'b00);
      checkFf("w01 done", 1'b0);

`ifdef ABFF_DRV_CHECK_EN
      // Feedback check: clean random traffic, then one corrupted cycle
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 32; k++) begin
         in_data = 8'($urandom);
         tick();
      end
      applyStimulus(1'b0, 8'h00);
      tick();
      tick();
      checkOutput("chk clean", {mismatch0, mismatch1}, 2'b00);
      inv = 1'b1;
      tick();
      inv = 1'b0;
      checkOutput("chk hit", {mismatch0, mismatch1}, 2'b10);
      tick();
      tick();
      checkOutput("chk sticky", {mismatch0, mismatch1}, 2'b10);
      rst = 1'b1;
      tick();
      checkOutput("chk cleared", {mismatch0, mismatch1}, 2'b00);
      tick();
      rst = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
